// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port (fetch / load-store) memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH,
    OWNER_DATA
  } arb_owner_t;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  // Width code 11 is not a real size; the memory controller sees it as a word.
  function automatic logic [1:0] fwd_width(input logic [1:0] w);
    return (w == 2'b11) ? WIDTH_WORD : w;
  endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational winner pick between fetch and data requesters.
// MEMORY_ARBITER_ROUND_ROBIN_EN: alternate on contention; otherwise data always wins.
module memory_arbiter_select (
  input  logic f_req,
  input  logic d_req,
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  input  logic last_grant,  // 1 = data port won the previous grant
`endif
  output logic sel_f,
  output logic sel_d
);

  always_comb begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    sel_d = d_req & (~f_req | ~last_grant);
`else
    sel_d = d_req;
`endif
    sel_f = f_req & ~sel_d;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises fetch and load/store traffic onto one memory_controller port.
// Optional round-robin arbitration under MEMORY_ARBITER_ROUND_ROBIN_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_width,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] memory_read_address,
  input  logic [DATA_W-1:0] memory_read_data,
  output logic [1:0]        memory_write_width,
  output logic [ADDR_W-1:0] memory_write_address,
  output logic [DATA_W-1:0] memory_write_data,
  output logic              memory_write_enable,
  output logic              busy
);

  localparam logic [3:0] CNT_RD = 4'(MEM_LATENCY - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        width_q, width_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              sel_f, sel_d;
  logic              rd_access, wr_access;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  arb_owner_t last_q, last_d;

  memory_arbiter_select u_select (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_grant (last_q == OWNER_DATA),
    .sel_f      (sel_f),
    .sel_d      (sel_d)
  );
`else
  memory_arbiter_select u_select (
    .f_req (f_req),
    .d_req (d_req),
    .sel_f (sel_f),
    .sel_d (sel_d)
  );
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    width_d   = width_q;
    wdata_d   = wdata_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        d_gnt = d_req & sel_d;
        f_gnt = f_req & sel_f;
        if (d_gnt) begin
          owner_d = OWNER_DATA;
          addr_d  = d_addr;
          we_d    = d_we;
          width_d = d_width;
          wdata_d = d_wdata;
          cnt_d   = d_we ? 4'd0 : CNT_RD;
          state_d = ACCESS;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          last_d  = OWNER_DATA;
`endif
        end else if (f_gnt) begin
          owner_d = OWNER_FETCH;
          addr_d  = f_addr;
          we_d    = 1'b0;
          cnt_d   = CNT_RD;
          state_d = ACCESS;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          last_d  = OWNER_FETCH;
`endif
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else if (cnt_q == 4'd0) begin
          // Memory data is valid in the final ACCESS cycle; capture for the owner only.
          state_d = RESP;
          if (owner_q == OWNER_DATA) d_rdata_d = memory_read_data;
          else                       f_rdata_d = memory_read_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_FETCH;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      width_q   <= 2'b00;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_q    <= OWNER_FETCH;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      width_q   <= width_d;
      wdata_q   <= wdata_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  // Memory-side buses are zero except during the access they belong to.
  assign rd_access = (state_q == ACCESS) && !we_q;
  assign wr_access = (state_q == ACCESS) && we_q;

  assign memory_read_address  = rd_access ? addr_q : '0;
  assign memory_write_enable  = wr_access;
  assign memory_write_address = wr_access ? addr_q : '0;
  assign memory_write_data    = wr_access ? wdata_q : '0;
  assign memory_write_width   = wr_access ? fwd_width(width_q) : WIDTH_BYTE;

  assign f_rvalid = (state_q == RESP) && (owner_q == OWNER_FETCH);
  assign d_rvalid = (state_q == RESP) && (owner_q == OWNER_DATA);
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised scoreboard bench for memory_arbiter against a transaction-level model.
module tb_memory_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic [1:0]    d_width = 2'b00;
  logic [DW-1:0] d_wdata = '0;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, busy;
  logic [DW-1:0] f_rdata, d_rdata, memory_read_data, memory_write_data;
  logic [AW-1:0] memory_read_address, memory_write_address;
  logic [1:0]    memory_write_width;
  logic          memory_write_enable;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .memory_read_address(memory_read_address), .memory_read_data(memory_read_data),
    .memory_write_width(memory_write_width), .memory_write_address(memory_write_address),
    .memory_write_data(memory_write_data), .memory_write_enable(memory_write_enable),
    .busy(busy)
  );

  typedef struct { bit is_d; bit we; logic [DW-1:0] data; int due; } resp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [1:0] width; int due; } wr_t;

  resp_t         rq[$];
  wr_t           wq[$];
  int            checks = 0, errors = 0;
  int            cyc = 0, next_free = 0, cap_cyc = -1;
  bit            last_d = 1'b0, rst_prev = 1'b0, f_took = 1'b0, d_took = 1'b0;
  logic [DW-1:0] exp_f_rd = '0, exp_d_rd = '0, noise = '0;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= $urandom;
  end

  // Memory only returns the right word in the cycle the model expects a capture.
  assign memory_read_data = (cyc == cap_cyc) ? mem_f(memory_read_address) : noise;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor + reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    bit eg_d, eg_f, idle;
    resp_t r;
    wr_t w;
    logic [AW-1:0] a;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {f_gnt, d_gnt}, 0);
        chk("rst_rvalid", {f_rvalid, d_rvalid}, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_wen", memory_write_enable, 0);
        chk("rst_raddr", memory_read_address, 0);
        chk("rst_waddr", memory_write_address, 0);
        chk("rst_wdata", memory_write_data, 0);
        chk("rst_wwidth", memory_write_width, 0);
      end
      rq.delete();
      wq.delete();
      next_free = cyc + 1;
      cap_cyc   = -1;
      exp_f_rd  = '0;
      exp_d_rd  = '0;
      last_d    = 1'b0;
      f_took    = 1'b0;
      d_took    = 1'b0;
    end else begin
      idle = (cyc >= next_free);
      chk("busy", busy, !idle);
      eg_d = 1'b0;
      eg_f = 1'b0;
      if (idle) begin
        if (d_req && f_req) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          eg_d = !last_d;
`else
          eg_d = 1'b1;
`endif
          eg_f = !eg_d;
        end else begin
          eg_d = d_req;
          eg_f = f_req;
        end
      end
      chk("f_gnt", f_gnt, eg_f);
      chk("d_gnt", d_gnt, eg_d);
      f_took = f_gnt;
      d_took = d_gnt;
      if (eg_d || eg_f) begin
        last_d = eg_d;
        if (eg_d && d_we) begin
          wq.push_back('{addr: d_addr, data: d_wdata,
                         width: (d_width == 2'b11) ? 2'b10 : d_width, due: cyc + 1});
          rq.push_back('{is_d: 1'b1, we: 1'b1, data: '0, due: cyc + 2});
          next_free = cyc + 3;
        end else begin
          a = eg_d ? d_addr : f_addr;
          rq.push_back('{is_d: eg_d, we: 1'b0, data: mem_f(a), due: cyc + LAT + 1});
          cap_cyc   = cyc + LAT;
          next_free = cyc + LAT + 2;
        end
      end

      if (f_rvalid || d_rvalid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", {f_rvalid, d_rvalid}, 0);
        end else begin
          r = rq.pop_front();
          chk("rv_both", f_rvalid & d_rvalid, 0);
          chk("rv_port", d_rvalid, r.is_d);
          chk("rv_cycle", cyc, r.due);
          if (!r.we) begin
            if (r.is_d) exp_d_rd = r.data;
            else        exp_f_rd = r.data;
          end
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        chk("rv_missing", 0, 1);
      end

      if (memory_write_enable) begin
        if (wq.size() == 0) begin
          chk("unexpected_wen", memory_write_enable, 0);
        end else begin
          w = wq.pop_front();
          chk("w_cycle", cyc, w.due);
          chk("w_addr", memory_write_address, w.addr);
          chk("w_data", memory_write_data, w.data);
          chk("w_width", memory_write_width, w.width);
        end
      end else begin
        chk("wwidth_idle", memory_write_width, 0);
        if (wq.size() != 0 && wq[0].due <= cyc) begin
          w = wq.pop_front();
          chk("wen_missing", 0, 1);
        end
      end

      chk("f_rdata", f_rdata, exp_f_rd);
      chk("d_rdata", d_rdata, exp_d_rd);
    end
    rst_prev = rst;
  end

  // Each requester holds its request until granted, occasionally withdrawing.
  task automatic drive_rand(input int f_pct, input int d_pct);
    if (f_took || !f_req) begin
      f_req  = ($urandom_range(0, 99) < f_pct);
      f_addr = $urandom & 32'hFFFF_FFFC;
    end else if ($urandom_range(0, 15) == 0) begin
      f_req = 1'b0;
    end
    if (d_took || !d_req) begin
      d_req   = ($urandom_range(0, 99) < d_pct);
      d_we    = $urandom_range(0, 1) == 1;
      d_width = 2'($urandom_range(0, 3));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end else if ($urandom_range(0, 15) == 0) begin
      d_req = 1'b0;
    end
  endtask

  task automatic quiet(input int n);
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed fetch read and byte store.
    f_req = 1'b1; f_addr = 32'h100;
    @(posedge clk); #1 f_req = 1'b0;
    quiet(LAT + 4);
    d_req = 1'b1; d_we = 1'b1; d_width = 2'b00; d_addr = 32'h20; d_wdata = 32'hA5;
    @(posedge clk); #1 d_req = 1'b0;
    quiet(5);
    d_req = 1'b1; d_we = 1'b1; d_width = 2'b11; d_addr = 32'h24; d_wdata = 32'h1234_5678;
    @(posedge clk); #1 d_req = 1'b0;
    quiet(5);

    // Random traffic, then sustained contention.
    repeat (800) begin
      drive_rand(40, 40);
      @(posedge clk); #1;
    end
    quiet(LAT + 5);
    repeat (200) begin
      drive_rand(100, 100);
      @(posedge clk); #1;
    end
    quiet(LAT + 5);

    // Reset in the middle of a read access.
    f_req = 1'b1; f_addr = 32'h100;
    @(posedge clk); #1 f_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    f_req = 1'b1; f_addr = 32'h200;
    @(posedge clk); #1 f_req = 1'b0;
    quiet(LAT + 6);

    chk("queues_drained", rq.size() + wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single memory_controller port between two requesters: instruction fetch (port F, read-only) and load/store (port D, read/write).
- Sits between fetch_unit/execute_unit and the memory_controller, in preparation for the multi-cycle core.
- Serialises one transaction at a time with a req/gnt/rvalid handshake and a fixed, parameterised memory read latency.

Parameters:
ADDR_W, 32, width of all address ports (equals `MEMORY_DEPTH in the CPU build)
DATA_W, 32, width of all data ports (equals `MEMORY_WIDTH in the CPU build)
MEM_LATENCY, 1, cycles from read address presented to memory_read_data valid; legal range 1..15

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; one clock, reset is synchronous and active-high
f_req  in  1  fetch read request
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  fetch read data valid (1-cycle pulse)
f_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_width  in  2  00 byte, 01 half, 10 word, 11 treated as word
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid or store complete (1-cycle pulse)
d_rdata  out  DATA_W  load data
memory_read_address  out  ADDR_W  to memory_controller
memory_read_data  in  DATA_W  from memory_controller
memory_write_width  out  2  to memory_controller
memory_write_address  out  ADDR_W  to memory_controller
memory_write_data  out  DATA_W  to memory_controller
memory_write_enable  out  1  to memory_controller
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state IDLE, cnt 0, owner FETCH.
  - All registered outputs are 0: memory_* addresses, data, width, enable; f_rdata, d_rdata.
  - f_gnt, d_gnt, f_rvalid, d_rvalid, busy are all 0.
- gnt is Mealy and is asserted only in IDLE:
  - d_gnt = d_req & selected(D).
  - f_gnt = f_req & selected(F).
  - At most one gnt is high per cycle.
- Default priority: D wins when both request.
- Acceptance in cycle T (IDLE, gnt=1):
  - Latch owner, addr, we, width, and wdata.
  - Go to ACCESS.
  - Set cnt = MEM_LATENCY-1 for a read, or 0 for a write.
- ACCESS, read:
  - memory_read_address = latched addr; memory_write_enable = 0.
  - Decrement cnt each cycle.
  - When cnt==0: capture memory_read_data into the owner's rdata register, then go to RESP.
- ACCESS, write (D only), exactly one cycle:
  - memory_write_enable = 1, with latched address, data, and width (11 forwarded as 10).
  - Then go to RESP.
- RESP, one cycle:
  - The owner's rvalid = 1; rdata holds the captured value (unchanged for writes).
  - Then go to IDLE.
- Latency from acceptance to rvalid: read = MEM_LATENCY+1 cycles; write = 2 cycles.
- Minimum request spacing is MEM_LATENCY+2 cycles, because gnt is never issued in ACCESS or RESP.
- memory_write_enable is high only in write-ACCESS; it is never high for fetch-owned or read transactions.
- memory_write_width = 0 outside write-ACCESS.
- rdata registers hold their last value until the next capture.
- Requesters hold req and attributes stable until gnt:
  - Dropping req before gnt: legal, no effect.
  - Changes after gnt: ignored.
- Reset mid-ACCESS or mid-RESP: next edge returns to IDLE; no rvalid pulse; write enable is low from that edge.
- Alignment and width legality are not checked; values pass through.

Optional Feature:
- Macro: MEMORY_ARBITER_ROUND_ROBIN_EN.
- Defined: when both request, the port not granted last wins.
  - A last-grant register updates on each gnt.
  - Reset value of last-grant = FETCH, so D wins the first contention.
- Undefined: fixed priority, D over F; no last-grant register.

Decomposition:
- Package memory_arbiter_pkg holds:
  - typedef arb_state_t {IDLE, ACCESS, RESP}
  - typedef arb_owner_t {OWNER_FETCH, OWNER_DATA}
  - constants WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10
- One sub-module, memory_arbiter_select: combinational winner pick from f_req, d_req, and last-grant; contains the round-robin/fixed-priority logic under the macro.

Test Plan:
- MEM_LATENCY=1; f_req, f_addr=0x100 at T with memory returning 0xDEADBEEF → f_gnt at T, memory_read_address=0x100 at T+1, f_rvalid with f_rdata=0xDEADBEEF at T+2, busy high T+1..T+2.
- d_req, d_we=1, d_width=00, d_addr=0x20, d_wdata=0xA5 at T → memory_write_enable=1 only at T+1 with address 0x20, width 00, data 0xA5; d_rvalid at T+2; f_rvalid stays 0.
- f_req and d_req both high continuously, fixed priority → D granted on every acceptance; F never granted while d_req holds.
- Same stimulus with MEMORY_ARBITER_ROUND_ROBIN_EN, MEM_LATENCY=3 → grants alternate D, F, D, F every 5 cycles; read rvalid 4 cycles after gnt.
- d_width=11 store at T → memory_write_width=10 at T+1.
- rst asserted during read-ACCESS (MEM_LATENCY=3, cycle T+2) → IDLE on next edge, no rvalid, busy=0; new f_req accepted the cycle after rst deasserts.
